// File: rtl/servo_bank.sv
// Multi-channel servo PWM sequencer: each channel plays a (pulse width, frame count)
// command against one shared free-running frame timer, optionally one channel at a time.
module servo_bank #(
    parameter int NCH         = 2,
    parameter int FRAME_TICKS = 1000000,
    parameter int PW_W        = 17,
    parameter int HOLD_W      = 10,
    parameter bit EXCLUSIVE   = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         cmd_valid,
    input  logic [NCH*PW_W-1:0]    cmd_pw,
    input  logic [NCH*HOLD_W-1:0]  cmd_frames,
    output logic [NCH-1:0]         cmd_accept,
    output logic [NCH-1:0]         cmd_reject,
    output logic [NCH-1:0]         busy,
    output logic [NCH-1:0]         done,
    output logic [NCH-1:0]         pwm
);

    localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    // Comparisons run one bit wider than either operand so pw and the frame length never truncate.
    localparam int CMP_W = ((PW_W > CNT_W) ? PW_W : CNT_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_TICKS - 1);
    localparam logic [CMP_W-1:0] FT_CMP  = CMP_W'(FRAME_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_RUN
    } state_t;

    state_t            state_q  [NCH];
    state_t            state_d  [NCH];
    logic [PW_W-1:0]   pw_q     [NCH];
    logic [PW_W-1:0]   pw_d     [NCH];
    logic [HOLD_W-1:0] frames_q [NCH];
    logic [HOLD_W-1:0] frames_d [NCH];
    logic [HOLD_W-1:0] rem_q    [NCH];
    logic [HOLD_W-1:0] rem_d    [NCH];

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0]    accept_q, accept_d;
    logic [NCH-1:0]    reject_q, reject_d;
    logic [NCH-1:0]    done_q, done_d;
    logic [NCH-1:0]    pwm_q, pwm_d;
    logic [NCH-1:0]    busy_now;
    logic [NCH-1:0]    cmd_ok;
    logic              any_busy;

    always_comb begin
        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end

    always_comb begin
        any_busy = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            busy_now[i] = (state_q[i] != ST_IDLE);
            any_busy    = any_busy | busy_now[i];
        end
    end

    always_comb begin
        logic [PW_W-1:0]   pw_in;
        logic [HOLD_W-1:0] fr_in;
        logic              take;
        logic              lower_req;
        logic              pulse_on;

        pw_in     = '0;
        fr_in     = '0;
        take      = 1'b0;
        lower_req = 1'b0;
        pulse_on  = 1'b0;
        accept_d  = '0;
        reject_d  = '0;
        done_d    = '0;
        pwm_d     = '0;
        cmd_ok    = '0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i]  = state_q[i];
            pw_d[i]     = pw_q[i];
            frames_d[i] = frames_q[i];
            rem_d[i]    = rem_q[i];
        end

        for (int i = 0; i < NCH; i++) begin
            pw_in     = cmd_pw[i*PW_W +: PW_W];
            fr_in     = cmd_frames[i*HOLD_W +: HOLD_W];
            cmd_ok[i] = (fr_in != '0) && (CMP_W'(pw_in) < FT_CMP) && (state_q[i] == ST_IDLE);
            // Lower index wins when several idle channels ask in the same cycle.
            take      = cmd_valid[i] && cmd_ok[i] &&
                        (!EXCLUSIVE || (!any_busy && !lower_req));
            lower_req = lower_req | (cmd_valid[i] & cmd_ok[i]);
            accept_d[i] = take;
            reject_d[i] = cmd_valid[i] && !take;
            pulse_on    = CMP_W'(cnt_q) < CMP_W'(pw_q[i]);

            case (state_q[i])
                ST_IDLE: begin
                    if (take) begin
                        state_d[i]  = ST_PENDING;
                        pw_d[i]     = pw_in;
                        frames_d[i] = fr_in;
                    end
                end
                ST_PENDING: begin
                    // The counter==0 cycle already drives the first high bit of the frame.
                    if (cnt_q == '0) begin
                        state_d[i] = ST_RUN;
                        rem_d[i]   = frames_q[i];
                        pwm_d[i]   = pulse_on;
                    end
                end
                ST_RUN: begin
                    pwm_d[i] = pulse_on;
                    if (cnt_q == CNT_MAX) begin
                        rem_d[i] = rem_q[i] - HOLD_W'(1);
                        if (rem_q[i] == HOLD_W'(1)) begin
                            state_d[i] = ST_IDLE;
                            done_d[i]  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            accept_q <= '0;
            reject_q <= '0;
            done_q   <= '0;
            pwm_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_IDLE;
            end
        end else begin
            cnt_q    <= cnt_d;
            accept_q <= accept_d;
            reject_q <= reject_d;
            done_q   <= done_d;
            pwm_q    <= pwm_d;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Command payload registers are only meaningful while the channel state says so.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            pw_q[i]     <= pw_d[i];
            frames_q[i] <= frames_d[i];
            rem_q[i]    <= rem_d[i];
        end
    end

    assign cmd_accept = accept_q;
    assign cmd_reject = reject_q;
    assign busy       = busy_now;
    assign done       = done_q;
    assign pwm        = pwm_q;

endmodule

// File: tb/tb_servo_bank.sv
// Bench for servo_bank: an exclusive and an independent instance share one stimulus stream
// and are checked every cycle against a timestamp-based model of each command's schedule.
module tb_servo_bank;

    localparam int NCH    = 2;
    localparam int FT     = 100;
    localparam int PW_W   = 17;
    localparam int HOLD_W = 10;

    logic                  clk;
    logic                  reset;
    logic [NCH-1:0]        cmd_valid;
    logic [NCH*PW_W-1:0]   cmd_pw;
    logic [NCH*HOLD_W-1:0] cmd_frames;

    logic [NCH-1:0] acc_x, rej_x, busy_x, done_x, pwm_x;
    logic [NCH-1:0] acc_i, rej_i, busy_i, done_i, pwm_i;

    servo_bank #(.NCH(NCH), .FRAME_TICKS(FT), .PW_W(PW_W), .HOLD_W(HOLD_W), .EXCLUSIVE(1'b1)) dut_x (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_pw(cmd_pw), .cmd_frames(cmd_frames),
        .cmd_accept(acc_x), .cmd_reject(rej_x), .busy(busy_x), .done(done_x), .pwm(pwm_x)
    );

    servo_bank #(.NCH(NCH), .FRAME_TICKS(FT), .PW_W(PW_W), .HOLD_W(HOLD_W), .EXCLUSIVE(1'b0)) dut_i (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_pw(cmd_pw), .cmd_frames(cmd_frames),
        .cmd_accept(acc_i), .cmd_reject(rej_i), .busy(busy_i), .done(done_i), .pwm(pwm_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: per mode (0 = exclusive, 1 = independent) and channel, the cycle the run
    // starts (counter==0), the cycle busy drops, and the command fields.
    int m_s   [2][NCH];
    int m_end [2][NCH];
    int m_pw  [2][NCH];
    int m_fr  [2][NCH];
    logic [NCH-1:0] e_acc [2];
    logic [NCH-1:0] e_rej [2];
    int cyc;
    int base;
    int n_cmp;
    int n_err;

    function automatic int cnt_at(int k);
        return (k - base) % FT;
    endfunction

    function automatic bit busy_at(int m, int c, int k);
        return (m_end[m][c] >= 0) && (k < m_end[m][c]);
    endfunction

    function automatic bit pwm_at(int m, int c, int k);
        int d;
        if (m_end[m][c] < 0 || k <= m_s[m][c]) return 1'b0;
        d = k - m_s[m][c] - 1;
        return ((d / FT) < m_fr[m][c]) && ((d % FT) < m_pw[m][c]);
    endfunction

    function automatic bit any_busy_model(int k);
        bit b;
        b = 1'b0;
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < NCH; c++)
                b = b | busy_at(m, c, k);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        bit reset_now;
        reset_now = reset;
        if (!reset_now) begin
            for (int m = 0; m < 2; m++) begin
                bit anyb;
                bit lower;
                anyb  = 1'b0;
                lower = 1'b0;
                for (int c = 0; c < NCH; c++) anyb = anyb | busy_at(m, c, cyc);
                for (int c = 0; c < NCH; c++) begin
                    int  pw;
                    int  fr;
                    bit  ok;
                    bit  take;
                    pw   = int'(cmd_pw[c*PW_W +: PW_W]);
                    fr   = int'(cmd_frames[c*HOLD_W +: HOLD_W]);
                    ok   = (fr != 0) && (pw < FT) && !busy_at(m, c, cyc);
                    take = cmd_valid[c] && ok && ((m == 1) || (!anyb && !lower));
                    lower = lower | (cmd_valid[c] && ok);
                    e_acc[m][c] = take;
                    e_rej[m][c] = cmd_valid[c] && !take;
                    if (take) begin
                        m_s[m][c]   = cyc + FT - cnt_at(cyc);
                        m_end[m][c] = m_s[m][c] + fr * FT;
                        m_pw[m][c]  = pw;
                        m_fr[m][c]  = fr;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (reset_now) begin
            base = cyc;
            for (int m = 0; m < 2; m++) begin
                e_acc[m] = '0;
                e_rej[m] = '0;
                for (int c = 0; c < NCH; c++) m_end[m][c] = -1;
            end
        end
        for (int m = 0; m < 2; m++) begin
            logic [NCH-1:0] eb, ed, ep;
            for (int c = 0; c < NCH; c++) begin
                eb[c] = busy_at(m, c, cyc);
                ed[c] = (m_end[m][c] == cyc);
                ep[c] = pwm_at(m, c, cyc);
            end
            if (m == 0) begin
                chk("x_accept", acc_x, e_acc[0]);
                chk("x_reject", rej_x, e_rej[0]);
                chk("x_busy", busy_x, eb);
                chk("x_done", done_x, ed);
                chk("x_pwm", pwm_x, ep);
            end else begin
                chk("i_accept", acc_i, e_acc[1]);
                chk("i_reject", rej_i, e_rej[1]);
                chk("i_busy", busy_i, eb);
                chk("i_done", done_i, ed);
                chk("i_pwm", pwm_i, ep);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr();
        cmd_valid  = '0;
        cmd_pw     = '0;
        cmd_frames = '0;
    endtask

    task automatic set_cmd(input int c, input int pw, input int fr);
        cmd_valid[c]                  = 1'b1;
        cmd_pw[c*PW_W +: PW_W]        = PW_W'(pw);
        cmd_frames[c*HOLD_W +: HOLD_W] = HOLD_W'(fr);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            if (!any_busy_model(cyc)) break;
            step();
        end
        run(2);
    endtask

    task automatic wait_count(input int v);
        for (int i = 0; i < 2 * FT; i++) begin
            if (cnt_at(cyc) == v) break;
            step();
        end
    endtask

    task automatic one_cmd(input int c, input int pw, input int fr);
        set_cmd(c, pw, fr);
        step();
        clr();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        base  = 0;
        for (int m = 0; m < 2; m++) begin
            e_acc[m] = '0;
            e_rej[m] = '0;
            for (int c = 0; c < NCH; c++) begin
                m_end[m][c] = -1;
                m_s[m][c]   = 0;
                m_pw[m][c]  = 0;
                m_fr[m][c]  = 0;
            end
        end
        clr();

        // Reset for three cycles, garbage on the command bus.
        reset = 1'b1;
        set_cmd(0, 10, 3);
        run(3);
        reset = 1'b0;
        clr();

        // Single move issued at counter 40.
        wait_count(40);
        one_cmd(0, 10, 3);
        wait_idle();

        // Simultaneous requests: exclusive takes ch0 only, independent takes both.
        wait_count(17);
        set_cmd(0, 20, 2);
        set_cmd(1, 5, 4);
        step();
        clr();
        run(30);
        one_cmd(1, 8, 1);
        // Hold a ch1 request until the exclusive instance accepts it.
        set_cmd(1, 7, 1);
        for (int i = 0; i < 1000; i++) begin
            step();
            if (e_acc[0][1]) break;
        end
        clr();
        wait_idle();

        // Illegal and edge commands.
        one_cmd(0, 10, 0);
        one_cmd(1, 100, 2);
        run(3);
        one_cmd(0, 99, 1);
        wait_idle();
        one_cmd(1, 0, 2);
        wait_idle();

        // Reset during the fifth high cycle of a pw=30 pulse, then a normal move.
        one_cmd(0, 30, 2);
        for (int i = 0; i < 3 * FT; i++) begin
            if (cyc >= m_s[0][0] + 5) break;
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(2);
        one_cmd(0, 12, 1);
        wait_idle();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            clr();
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 15) == 0)
                    set_cmd(c, int'($urandom_range(0, 105)), int'($urandom_range(0, 3)));
            end
            step();
        end
        clr();
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
